// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the pipeline (master) and the multiply/divide unit (slave).
// The slave side feeds the Hi/Lo register write port directly.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Flush;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HiIn;
    logic [WIDTH-1:0] LoIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HiWriteData;
    logic [WIDTH-1:0] LoWriteData;
    logic             HiWriteEnable;
    logic             LoWriteEnable;
    logic             DivZero;

    modport master (
        output Start, Flush, Op, A, B, HiIn, LoIn,
        input  Busy, Done, HiWriteData, LoWriteData, HiWriteEnable, LoWriteEnable, DivZero
    );

    modport slave (
        input  Start, Flush, Op, A, B, HiIn, LoIn,
        output Busy, Done, HiWriteData, LoWriteData, HiWriteEnable, LoWriteEnable, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding the Hi/Lo registers.
// Define MDU_MADD_EN to add MADD/MSUB accumulation of {HiIn,LoIn}.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_div_unit_if.slave bus
);
    localparam int LATENCY = WIDTH + 2;
    localparam int CNT_W   = $clog2(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      divz_q, divz_d;
    logic signed [WIDTH-1:0]   hi_q, hi_d;
    logic signed [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]          mag_q, mag_d;
    logic signed [WIDTH-1:0]   opa_q, opa_d;
    logic signed [WIDTH-1:0]   opb_q, opb_d;
    logic                      div_q, div_d;
    logic                      sgn_q, sgn_d;
    logic                      neg_q, neg_d;
    logic                      rneg_q, rneg_d;
    logic                      dz_q, dz_d;
`ifdef MDU_MADD_EN
    logic                      accen_q, accen_d;
    logic                      accsub_q, accsub_d;
    logic [WIDTH-1:0]          hiin_q, hiin_d;
    logic [WIDTH-1:0]          loin_q, loin_d;
`else
    logic                      unused_acc_in;
    assign unused_acc_in = ^{bus.HiIn, bus.LoIn};
`endif

    logic                      op_div, op_sgn;
    logic [WIDTH-1:0]          a_mag, b_mag;
    logic [WIDTH:0]            sum, top, diff;
    logic [2*WIDTH-1:0]        res;

    function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_mul(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? -p : p;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_div(input logic [2*WIDTH-1:0] rq,
                                                   input logic qneg, input logic rneg);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        q = rq[WIDTH-1:0];
        r = rq[2*WIDTH-1:WIDTH];
        if (qneg) q = -q;
        if (rneg) r = -r;
        return {r, q};
    endfunction

    // Unused opcodes (and MADD/MSUB when not built) decode as MULTU.
    always_comb begin
        op_div = (bus.Op == 3'b010) || (bus.Op == 3'b011);
`ifdef MDU_MADD_EN
        op_sgn = (bus.Op == 3'b000) || (bus.Op == 3'b010) || (bus.Op == 3'b100) || (bus.Op == 3'b101);
`else
        op_sgn = (bus.Op == 3'b000) || (bus.Op == 3'b010);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
`ifdef MDU_MADD_EN
        accen_d  = accen_q;
        accsub_d = accsub_q;
        hiin_d   = hiin_q;
        loin_d   = loin_q;
`endif
        a_mag = abs_if(opa_q, sgn_q);
        b_mag = abs_if(opb_q, sgn_q);
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : '0)};
        top   = acc_q[2*WIDTH-1:WIDTH-1];
        diff  = top - {1'b0, mag_q};

        res = div_q ? fix_div(acc_q, neg_q, rneg_q) : fix_mul(acc_q, neg_q);
`ifdef MDU_MADD_EN
        if (accen_q) res = accsub_q ? ({hiin_q, loin_q} - res) : ({hiin_q, loin_q} + res);
`endif
        if (dz_q) res = {opa_q, {WIDTH{1'b1}}};

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.Start && !bus.Flush) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    opa_d   = bus.A;
                    opb_d   = bus.B;
                    div_d   = op_div;
                    sgn_d   = op_sgn;
`ifdef MDU_MADD_EN
                    accen_d  = (bus.Op == 3'b100) || (bus.Op == 3'b101);
                    accsub_d = (bus.Op == 3'b101);
                    hiin_d   = bus.HiIn;
                    loin_d   = bus.LoIn;
`endif
                end
            end
            S_CALC: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    // First CALC cycle strips operand signs; iterations follow.
                    mag_d  = div_q ? b_mag : a_mag;
                    acc_d  = {{WIDTH{1'b0}}, (div_q ? a_mag : b_mag)};
                    neg_d  = sgn_q && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
                    rneg_d = sgn_q && opa_q[WIDTH-1];
                    dz_d   = div_q && (opb_q == '0);
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    if (!div_q)
                        acc_d = {sum, acc_q[WIDTH-1:1]};
                    else if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    if (cnt_q == CNT_W'(WIDTH))
                        state_d = S_FIX;
                    else
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                if (bus.Flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    divz_d  = dz_q;
                    hi_d    = res[2*WIDTH-1:WIDTH];
                    lo_d    = res[WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge Clk) begin
        acc_q  <= acc_d;
        mag_q  <= mag_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        div_q  <= div_d;
        sgn_q  <= sgn_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        dz_q   <= dz_d;
`ifdef MDU_MADD_EN
        accen_q  <= accen_d;
        accsub_q <= accsub_d;
        hiin_q   <= hiin_d;
        loin_q   <= loin_d;
`endif
    end

    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.HiWriteEnable = done_q;
    assign bus.LoWriteEnable = done_q;
    assign bus.DivZero       = divz_q;
    assign bus.HiWriteData   = hi_q;
    assign bus.LoWriteData   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of the MIPS Hi/Lo results.
module tb_mult_div_unit;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {DivZero, Hi, Lo}.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hiin, input logic [31:0] loin);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: return {1'b0, 64'(sa * sb)};
            3'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
`ifdef MDU_MADD_EN
            3'd4: begin
                p = {hiin, loin} + 64'(sa * sb);
                return {1'b0, p};
            end
            3'd5: begin
                p = {hiin, loin} - 64'(sa * sb);
                return {1'b0, p};
            end
`endif
            default: return {1'b0, ua * ub};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
    endtask

    // One full op. poke_busy re-pulses Start mid-CALC; poke_done drives Start+Flush in the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hiin, input logic [31:0] loin, input string tag,
                          input bit poke_busy, input bit poke_done);
        logic [64:0] exp;
        bit          early;
        exp = model(op, a, b, hiin, loin);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b; bus.HiIn = hiin; bus.LoIn = loin;
        @(negedge clk);
        idle_inputs();
        chk({tag, ".busy"}, 64'(bus.Busy), 64'd1);
        early = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (poke_busy && k == 5) begin
                bus.Start = 1'b1; bus.Op = 3'd3; bus.A = ~a; bus.B = b ^ 32'h1234;
                bus.HiIn = ~hiin; bus.LoIn = ~loin;
            end
            @(negedge clk);
            idle_inputs();
            if (bus.Done || bus.HiWriteEnable || bus.LoWriteEnable || !bus.Busy) early = 1'b1;
        end
        chk({tag, ".early"}, 64'(early), 64'd0);
        @(negedge clk);
        chk({tag, ".we"}, 64'({bus.Done, bus.HiWriteEnable, bus.LoWriteEnable, bus.Busy}), 64'hF);
        chk({tag, ".hilo"}, {bus.HiWriteData, bus.LoWriteData}, exp[63:0]);
        chk({tag, ".dz"}, 64'(bus.DivZero), 64'(exp[64]));
        if (poke_done) begin
            bus.Start = 1'b1; bus.Flush = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        chk({tag, ".end"}, 64'({bus.Done, bus.HiWriteEnable, bus.Busy, bus.DivZero}), 64'd0);
        chk({tag, ".hold"}, {bus.HiWriteData, bus.LoWriteData}, exp[63:0]);
    endtask

    // Start an op, flush it at edge fe after the sampling edge, and confirm no write ever appears.
    task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int fe, input string tag);
        bit seen, busy_after;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        busy_after = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == fe) bus.Flush = 1'b1;
            @(negedge clk);
            bus.Flush = 1'b0;
            if (bus.Done || bus.HiWriteEnable || bus.LoWriteEnable) seen = 1'b1;
            if (k >= fe && bus.Busy) busy_after = 1'b1;
        end
        chk({tag, ".nodone"}, 64'(seen), 64'd0);
        chk({tag, ".idle"}, 64'(busy_after), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.Start = 1'b0; bus.Flush = 1'b0; bus.Op = 3'd0;
        bus.A = '0; bus.B = '0; bus.HiIn = '0; bus.LoIn = '0;
        repeat (3) @(negedge clk);
        chk("reset.ctl", 64'({bus.Busy, bus.Done, bus.HiWriteEnable, bus.LoWriteEnable, bus.DivZero}), 64'd0);
        chk("reset.data", {bus.HiWriteData, bus.LoWriteData}, 64'd0);
        rst_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, "mult_neg", 1'b0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, "div_neg", 1'b0, 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 32'h0, 32'h0, "divu_zero", 1'b0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'h0, 32'h0, "div_zero", 1'b0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, "div_ovf", 1'b0, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, "multu_max", 1'b1, 1'b0);
        run_op(3'd4, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, "madd", 1'b0, 1'b0);
        run_op(3'd5, 32'hFFFF_FFFD, 32'd7, 32'h1, 32'h5, "msub", 1'b1, 1'b0);
        run_op(3'd7, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, "op7", 1'b0, 1'b1);

        run_flush(3'd3, 32'd1000, 32'd7, 10, "flush_calc");
        run_op(3'd1, 32'd5, 32'd6, 32'h0, 32'h0, "after_flush", 1'b0, 1'b0);
        run_flush(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 34, "flush_fix");

        // Flush beats Start while idle.
        @(negedge clk);
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 3'd1; bus.A = 32'd3; bus.B = 32'd3;
        @(negedge clk);
        idle_inputs();
        chk("flush_start.busy", 64'(bus.Busy), 64'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 3'd0; bus.A = 32'd9; bus.B = 32'd9;
        @(negedge clk);
        idle_inputs();
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.ctl", 64'({bus.Busy, bus.Done, bus.HiWriteEnable, bus.LoWriteEnable, bus.DivZero}), 64'd0);
        chk("rst_mid.data", {bus.HiWriteData, bus.LoWriteData}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Done || bus.HiWriteEnable || bus.LoWriteEnable) seen = 1'b1;
        end
        chk("rst_mid.nowrite", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, $urandom, $urandom, $sformatf("rnd%0d_op%0d", i, op), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
